fb_scanout: RTL
===============

// Module: fb_scanout
// PURPOSE
// Pixel-clock scanout stage between display timing and the VGA pins. It maps screen (sx,sy)
// to framebuffer (read_x,read_y) with a runtime integer upscale (1x/2x/4x/8x) and a letterbox
// offset. It issues reads into the double framebuffer's read port and aligns de/hsync/vsync
// with the returned pixel data. Outside the image window it drives BORDER_COLOR; it also
// provides a built-in colour-bar test mode. Replaces ad-hoc scaling and VGA output logic.
// PARAMETERS
// CORDW         10       screen coordinate width (sx, sy)
// FB_WIDTH      160      framebuffer width in pixels
// FB_HEIGHT     120      framebuffer height in pixels
// FBXW          8        read_x width; FB_WIDTH  <= 2**FBXW
// FBYW          7        read_y width; FB_HEIGHT <= 2**FBYW
// CHAN_W        4        bits per colour channel; pixel = 3*CHAN_W, R in MSBs
// READ_LATENCY  1        framebuffer read latency in cycles, address to data (>=1)
// BORDER_COLOR  12'h000  colour outside the image window while de is high
// SYNC_IDLE     1'b1     hsync/vsync output level during reset
// PORTS
// clk            in   1         pixel clock
// rst_n          in   1         asynchronous active-low reset
// sx, sy         in   CORDW     screen position from display timing
// de             in   1         display enable
// hsync, vsync   in   1         syncs from display timing, already in pin polarity
// frame          in   1         one-cycle pulse at frame start
// scale_sel      in   2         upscale 0:1x 1:2x 2:4x 3:8x; sampled on frame
// offset_x       in   CORDW     image window left edge (screen px); sampled on frame
// offset_y       in   CORDW     image window top edge; sampled on frame
// test_mode      in   1         1 = colour bars instead of fb data; sampled on frame
// read_x         out  FBXW      framebuffer read column
// read_y         out  FBYW      framebuffer read row
// read_data      in   3*CHAN_W  framebuffer data, valid READ_LATENCY cycles after read_x/y
// vga_hsync      out  1         aligned hsync
// vga_vsync      out  1         aligned vsync
// vga_r/g/b      out  CHAN_W    colour; 0 whenever the aligned de is low
// BEHAVIOUR
// - Reset (async assert, sync release): read_x/y=0, vga_r/g/b=0, vga_h/vsync=SYNC_IDLE,
//   pipeline valid/de flags=0, config shadow regs = scale 0, offsets 0, test_mode 0.
// - Config: scale_sel/offset/test_mode are copied into shadow regs only in a cycle with frame=1.
//   Mid-frame changes have no visible effect until the next frame pulse.
// - Stage A (1 cycle): dx=sx-offset_x, dy=sy-offset_y, computed at CORDW+1 signed width.
//   in_win = dx>=0 && dy>=0 && (dx>>s)<FB_WIDTH && (dy>>s)<FB_HEIGHT, where s is the shadow scale.
//   If in_win: read_x=dx>>s, read_y=dy>>s (truncated). Otherwise read_x/y hold their last value.
//   Holding the address avoids out-of-range RAM reads.
// - Delay line: de, hsync, vsync, in_win and bar index go through READ_LATENCY+1 regs total
//   (stage A plus READ_LATENCY).
// - Output stage (1 cycle): if !de_d then rgb=0.
//   Else if !in_win_d then rgb=BORDER_COLOR.
//   Else if test_mode then rgb=bar colour, else rgb=read_data.
// - Latency: sx/sy/de/syncs to pins = READ_LATENCY+2 cycles; syncs and rgb are exactly aligned.
// - Test bars: 8 vertical bars, index=(read_x*8)/FB_WIDTH.
//   Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
//   Each bar colour is a 3-bit RGB mask, each set channel driven to all-ones.
// - Overflow: a window that extends past the screen edge is clipped naturally. An offset past the
//   active area gives all-border output. The dx/dy sign bit prevents wrap at sx<offset_x.
// - frame coinciding with an in-window pixel: the new config applies starting that same cycle.
// - Reset mid-line: outputs return to reset values immediately; no partial pixels after release.
// TESTING
// - Reset with de=1, sx=5: vga_r/g/b=0 and syncs=SYNC_IDLE; after release, first valid rgb
//   appears 3 cycles later (READ_LATENCY=1).
// - scale=2, offset 0, ram model data={x,y}: sx=13,sy=9 -> read_x=3, read_y=2; that pixel's rgb
//   reaches the pins at +3 cycles.
// - scale=1, offset_x=160, offset_y=120: sx=159 -> BORDER_COLOR; sx=160,sy=120 -> read (0,0);
//   sx=479 -> read_x=159; sx=480 -> border.
// - Change scale_sel 2->0 mid-frame: mapping unchanged until the frame pulse, then sx=200 ->
//   border (200>=160).
// - test_mode=1, scale=2: sx=0 -> rgb 0xFFF, sx=80 -> 0xFF0, sx=639 -> 0x000; de=0 -> 0.
// - Toggle hsync/vsync patterns at sx=600: outputs are the same patterns shifted by exactly
//   READ_LATENCY+2 cycles, also for READ_LATENCY=2.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Framebuffer read port between the scanout stage (master) and the framebuffer (slave).
interface fb_scanout_if #(
   parameter int unsigned FBXW  = 8,
   parameter int unsigned FBYW  = 7,
   parameter int unsigned PIX_W = 12
);
   logic [FBXW-1:0]  read_x;
   logic [FBYW-1:0]  read_y;
   logic [PIX_W-1:0] read_data;

   modport master (output read_x, read_y, input read_data);
   modport slave  (input read_x, read_y, output read_data);
endinterface

// File: rtl/fb_scanout.sv
// Pixel-clock scanout: maps screen to framebuffer coordinates with integer upscale and
// letterbox offset, reads the framebuffer and drives aligned VGA colour and syncs.
module fb_scanout #(
   parameter int unsigned         CORDW        = 10,
   parameter int unsigned         FB_WIDTH     = 160,
   parameter int unsigned         FB_HEIGHT    = 120,
   parameter int unsigned         FBXW         = 8,
   parameter int unsigned         FBYW         = 7,
   parameter int unsigned         CHAN_W       = 4,
   parameter int unsigned         READ_LATENCY = 1,
   parameter logic [3*CHAN_W-1:0] BORDER_COLOR = '0,
   parameter logic                SYNC_IDLE    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CORDW-1:0]  sx,
   input  logic [CORDW-1:0]  sy,
   input  logic              de,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              frame,
   input  logic [1:0]        scale_sel,
   input  logic [CORDW-1:0]  offset_x,
   input  logic [CORDW-1:0]  offset_y,
   input  logic              test_mode,
   fb_scanout_if.master      fb,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic [CHAN_W-1:0] vga_r,
   output logic [CHAN_W-1:0] vga_g,
   output logic [CHAN_W-1:0] vga_b
);

   localparam int unsigned      PIX_W   = 3 * CHAN_W;
   localparam int unsigned      DEPTH   = READ_LATENCY + 1;
   localparam logic [CORDW-1:0] FB_W_C  = CORDW'(FB_WIDTH);
   localparam logic [CORDW-1:0] FB_H_C  = CORDW'(FB_HEIGHT);
   localparam logic [FBXW+2:0]  BAR_DIV = (FBXW+3)'(FB_WIDTH);

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       in_win;
      logic       test;
      logic [2:0] bar;
   } pipe_t;

   localparam pipe_t PIPE_RST = '{de: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE,
                                  in_win: 1'b0, test: 1'b0, bar: 3'd0};

   logic [1:0]       scale_q;
   logic [CORDW-1:0] offx_q;
   logic [CORDW-1:0] offy_q;
   logic             test_q;

   logic [1:0]       scale_c;
   logic [CORDW-1:0] offx_c;
   logic [CORDW-1:0] offy_c;
   logic             test_c;
   logic [CORDW:0]   dx_c;
   logic [CORDW:0]   dy_c;
   logic [CORDW-1:0] sdx_c;
   logic [CORDW-1:0] sdy_c;
   logic             in_win_c;
   logic [2:0]       bar_c;
   pipe_t            pipe_a_c;
   pipe_t            pipe [DEPTH];
   pipe_t            pd;
   logic [PIX_W-1:0] rgb_c;

   function automatic logic [PIX_W-1:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] m;
      case (idx)
         3'd0:    m = 3'b111;
         3'd1:    m = 3'b110;
         3'd2:    m = 3'b011;
         3'd3:    m = 3'b010;
         3'd4:    m = 3'b101;
         3'd5:    m = 3'b100;
         3'd6:    m = 3'b001;
         default: m = 3'b000;
      endcase
      return {{CHAN_W{m[2]}}, {CHAN_W{m[1]}}, {CHAN_W{m[0]}}};
   endfunction

   // Config shadow, loaded only on the frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale_q <= 2'd0;
         offx_q  <= '0;
         offy_q  <= '0;
         test_q  <= 1'b0;
      end else if (frame) begin
         scale_q <= scale_sel;
         offx_q  <= offset_x;
         offy_q  <= offset_y;
         test_q  <= test_mode;
      end
   end

   // Stage A: a frame pulse makes the new config effective in its own cycle
   always_comb begin
      scale_c  = frame ? scale_sel : scale_q;
      offx_c   = frame ? offset_x  : offx_q;
      offy_c   = frame ? offset_y  : offy_q;
      test_c   = frame ? test_mode : test_q;
      dx_c     = {1'b0, sx} - {1'b0, offx_c};
      dy_c     = {1'b0, sy} - {1'b0, offy_c};
      sdx_c    = dx_c[CORDW-1:0] >> scale_c;
      sdy_c    = dy_c[CORDW-1:0] >> scale_c;
      in_win_c = !dx_c[CORDW] && !dy_c[CORDW] && (sdx_c < FB_W_C) && (sdy_c < FB_H_C);
      bar_c    = 3'({FBXW'(sdx_c), 3'b000} / BAR_DIV);
      pipe_a_c = '{de: de, hs: hsync, vs: vsync, in_win: in_win_c, test: test_c, bar: bar_c};
   end

   // Address register holds outside the window; control rides a delay line matching the RAM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb.read_x <= '0;
         fb.read_y <= '0;
         for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= PIPE_RST;
      end else begin
         if (in_win_c) begin
            fb.read_x <= FBXW'(sdx_c);
            fb.read_y <= FBYW'(sdy_c);
         end
         pipe[0] <= pipe_a_c;
         for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      pd    = pipe[DEPTH-1];
      rgb_c = '0;
      if (pd.de) begin
         if (!pd.in_win)  rgb_c = BORDER_COLOR;
         else if (pd.test) rgb_c = bar_rgb(pd.bar);
         else              rgb_c = fb.read_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hsync <= SYNC_IDLE;
         vga_vsync <= SYNC_IDLE;
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
      end else begin
         vga_hsync <= pd.hs;
         vga_vsync <= pd.vs;
         vga_r     <= rgb_c[PIX_W-1 -: CHAN_W];
         vga_g     <= rgb_c[2*CHAN_W-1 -: CHAN_W];
         vga_b     <= rgb_c[CHAN_W-1:0];
      end
   end

endmodule
